// File: rtl/demux_8x1_sched_pkg.sv
// Shared widths and state encoding for the demux_8x1 sequencer.
package demux_8x1_sched_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/demux_8x1_sched_next_ch_find.sv
// Finds the lowest set mask bit, either from bit 0 (first=1) or strictly above cur.
module demux_8x1_sched_next_ch_find
  import demux_8x1_sched_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Descending scan so the lowest qualifying bit is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_8x1_sched.sv
// Frame sequencer: snapshots a channel mask and routes one serial bit per enabled channel, ascending.
module demux_8x1_sched
  import demux_8x1_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [SEL_W-1:0] sel,
  output logic             dm_data,
  output logic             dm_strobe,
  output logic [NCH-1:0]   ch_out,
  output logic             frame_done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             dm_data_q, dm_data_d;
  logic             dm_strobe_q, dm_strobe_d;
  logic [NCH-1:0]   ch_out_q, ch_out_d;

  logic [SEL_W-1:0] start_nxt, adv_nxt;
  logic             start_found, adv_found;

  // Frame-start search on the live mask.
  demux_8x1_sched_next_ch_find u_find_start (
    .mask  (ch_mask),
    .cur   ('0),
    .first (1'b1),
    .nxt   (start_nxt),
    .found (start_found)
  );

  // Advance search on the snapshot, strictly above the current channel.
  demux_8x1_sched_next_ch_find u_find_adv (
    .mask  (mask_q),
    .cur   (sel_q),
    .first (1'b0),
    .nxt   (adv_nxt),
    .found (adv_found)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    dm_data_d   = dm_data_q;
    dm_strobe_d = 1'b0;
    ch_out_d    = ch_out_q;

    case (state_q)
      ST_IDLE: begin
        if (en && start_found) begin
          mask_d  = ch_mask;
          sel_d   = start_nxt;
          state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (din_valid) begin
          dm_data_d       = din;
          dm_strobe_d     = 1'b1;
          ch_out_d[sel_q] = din;
          if (adv_found) begin
            sel_d = adv_nxt;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Back-to-back frames re-snapshot here; otherwise rest in IDLE.
        if (en && start_found) begin
          mask_d  = ch_mask;
          sel_d   = start_nxt;
          state_d = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      sel_q       <= '0;
      dm_data_q   <= 1'b0;
      dm_strobe_q <= 1'b0;
      ch_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      dm_data_q   <= dm_data_d;
      dm_strobe_q <= dm_strobe_d;
      ch_out_q    <= ch_out_d;
    end
  end

  // Status outputs decode directly from the state register.
  assign din_ready  = (state_q == ST_SERVE) && en;
  assign frame_done = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);

  assign sel       = sel_q;
  assign dm_data   = dm_data_q;
  assign dm_strobe = dm_strobe_q;
  assign ch_out    = ch_out_q;

endmodule

// File: tb/tb_demux_8x1_sched.sv
// Directed bench for demux_8x1_sched with hand-computed expectations.
module tb_demux_8x1_sched;

  logic       clk = 1'b0;
  logic       rst, en, din, din_valid;
  logic [7:0] ch_mask;
  logic       din_ready, dm_data, dm_strobe, frame_done, busy;
  logic [2:0] sel;
  logic [7:0] ch_out;

  int checks = 0;
  int errors = 0;

  demux_8x1_sched dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ch_mask    (ch_mask),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sel        (sel),
    .dm_data    (dm_data),
    .dm_strobe  (dm_strobe),
    .ch_out     (ch_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sel"},  32'(sel), 32'd0);
    check({tag, ".data"}, 32'(dm_data), 32'd0);
    check({tag, ".stb"},  32'(dm_strobe), 32'd0);
    check({tag, ".chout"}, 32'(ch_out), 32'd0);
    check({tag, ".fdone"}, 32'(frame_done), 32'd0);
    check({tag, ".rdy"},  32'(din_ready), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1; en = 1'b1; ch_mask = 8'hFF; din = 1'b1; din_valid = 1'b1;

    // 1: reset with toggling inputs, then release with en low
    tick();
    en = 1'b0; din = 1'b0; din_valid = 1'b0; ch_mask = 8'h5A;
    tick();
    check_all_zero("rst");
    rst = 1'b0; en = 1'b0; ch_mask = 8'hFF; din_valid = 1'b1;
    tick();
    check_all_zero("rst_rel");

    // empty mask never leaves IDLE
    en = 1'b1; ch_mask = 8'h00;
    tick();
    check("mask0.busy", 32'(busy), 32'd0);
    tick();
    check("mask0.fdone", 32'(frame_done), 32'd0);

    // 2: full mask, pattern 1,0,1,1,0,0,1,0 on channels 0..7
    pat = 8'b0100_1101;
    ch_mask = 8'hFF; din_valid = 1'b1; din = pat[0];
    tick();
    check("full.start_sel", 32'(sel), 32'd0);
    check("full.start_rdy", 32'(din_ready), 32'd1);
    check("full.start_stb", 32'(dm_strobe), 32'd0);
    for (int i = 0; i < 8; i++) begin
      din = pat[i];
      tick();
      check("full.data", 32'(dm_data), 32'(pat[i]));
      check("full.stb", 32'(dm_strobe), 32'd1);
      check("full.sel", 32'(sel), (i < 7) ? 32'(i + 1) : 32'd7);
      check("full.fdone", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
    end
    check("full.chout", 32'(ch_out), 32'h4D);
    check("full.done_rdy", 32'(din_ready), 32'd0);
    tick();
    check("full.b2b_sel", 32'(sel), 32'd0);
    check("full.b2b_fdone", 32'(frame_done), 32'd0);
    check("full.b2b_stb", 32'(dm_strobe), 32'd0);
    check("full.b2b_busy", 32'(busy), 32'd1);

    // 3: sparse mask 1010_0100 from a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1; ch_mask = 8'b1010_0100; din_valid = 1'b1; din = 1'b0;
    tick();
    check("sparse.sel0", 32'(sel), 32'd2);
    tick();
    check("sparse.sel1", 32'(sel), 32'd5);
    din = 1'b1;
    tick();
    check("sparse.sel2", 32'(sel), 32'd7);
    check("sparse.fdone_early", 32'(frame_done), 32'd0);
    tick();
    check("sparse.fdone", 32'(frame_done), 32'd1);
    check("sparse.chout", 32'(ch_out), 32'hA0);
    en = 1'b0;
    tick();
    check("sparse.idle_busy", 32'(busy), 32'd0);
    check("sparse.idle_fdone", 32'(frame_done), 32'd0);

    // 4: valid drops for 3 cycles at sel=4
    en = 1'b1; ch_mask = 8'hFF; din = 1'b1; din_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("stall.sel_pre", 32'(sel), 32'd4);
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.sel", 32'(sel), 32'd4);
      check("stall.stb", 32'(dm_strobe), 32'd0);
      check("stall.rdy", 32'(din_ready), 32'd1);
    end
    din_valid = 1'b1; din = 1'b0;
    tick();
    check("stall.resume_sel", 32'(sel), 32'd5);
    check("stall.resume_stb", 32'(dm_strobe), 32'd1);
    check("stall.chout", 32'(ch_out), 32'hAF);
    en = 1'b0;
    tick();

    // 5: mask change mid-frame is ignored until next snapshot
    en = 1'b1; ch_mask = 8'hFF; din = 1'b1; din_valid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    check("remask.sel3", 32'(sel), 32'd3);
    ch_mask = 8'h01;
    tick();
    check("remask.sel4", 32'(sel), 32'd4);
    for (int i = 0; i < 3; i++) tick();
    check("remask.sel7", 32'(sel), 32'd7);
    check("remask.fdone_early", 32'(frame_done), 32'd0);
    tick();
    check("remask.fdone", 32'(frame_done), 32'd1);
    tick();
    check("remask.new_sel", 32'(sel), 32'd0);
    check("remask.new_busy", 32'(busy), 32'd1);
    din = 1'b0;
    tick();
    check("remask.single_fdone", 32'(frame_done), 32'd1);
    check("remask.chout", 32'(ch_out), 32'hFE);
    en = 1'b0;
    tick();

    // 6a: en drop at sel=5
    en = 1'b1; ch_mask = 8'hFF; din = 1'b1; din_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("abort.sel5", 32'(sel), 32'd5);
    en = 1'b0;
    tick();
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.fdone", 32'(frame_done), 32'd0);
    check("abort.chout", 32'(ch_out), 32'hFF);
    check("abort.sel", 32'(sel), 32'd5);
    check("abort.data", 32'(dm_data), 32'd1);
    check("abort.rdy", 32'(din_ready), 32'd0);
    tick();
    check("abort.fdone2", 32'(frame_done), 32'd0);

    // 6b: reset at sel=5
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("rst5.sel5", 32'(sel), 32'd5);
    rst = 1'b1;
    tick();
    check_all_zero("rst5");
    rst = 1'b0; en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
